// File: rtl/mem_access_ctrl_if.sv
// Bundle of the MEM-stage pipeline inputs, the data-memory request/ack port
// and the stall/result outputs of the memory access controller.
interface mem_access_ctrl_if;
    // EX/MEM register side
    logic        MemRead_m;
    logic        MemWrite_m;
    logic [31:0] address;
    logic [31:0] data_m;
    // Data memory port
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    // Pipeline control and MEM/WB results
    logic        stall;
    logic [31:0] rdata_o;
    logic        err_o;

    // Controller view
    modport master (
        input  MemRead_m, MemWrite_m, address, data_m, mem_ack, mem_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, stall, rdata_o, err_o
    );

    // Pipeline / memory environment view
    modport slave (
        output MemRead_m, MemWrite_m, address, data_m, mem_ack, mem_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, stall, rdata_o, err_o
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: turns each load/store held in the EX/MEM
// register into one req/ack transaction, stalls the pipeline until it
// completes, returns load data and pulses err_o on misaligned or
// read+write accesses and on memory timeouts.
module mem_access_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_access_ctrl_if.master bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;
    localparam logic [1:0] ST_FAULT = 2'd3;

    // Counter value of the last REQ cycle before the access is abandoned
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic [1:0]       state_r;
    logic [1:0]       next_state_s;
    logic [CNT_W-1:0] cnt_r;
    logic             mem_req_r;
    logic             mem_we_r;
    logic [31:0]      mem_addr_r;
    logic [31:0]      mem_wdata_r;
    logic [31:0]      rdata_r;
    logic             err_r;
    logic             access_s;
    logic             illegal_s;
    logic             stall_s;

    // Decode of the instruction currently held in EX/MEM
    always_comb begin
        access_s  = bus.MemRead_m | bus.MemWrite_m;
        illegal_s = (bus.MemRead_m & bus.MemWrite_m) | (bus.address[1:0] != 2'b00);
    end

    // Next-state selection; an ack in the last REQ cycle still wins over timeout
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (access_s) begin
                    if (illegal_s) begin
                        next_state_s = ST_FAULT;
                    end else begin
                        next_state_s = ST_REQ;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (bus.mem_ack) begin
                    next_state_s = ST_DONE;
                end else if (cnt_r == CNT_LAST) begin
                    next_state_s = ST_FAULT;
                end else begin
                    next_state_s = ST_REQ;
                end
            end
            ST_DONE:  next_state_s = ST_IDLE;
            ST_FAULT: next_state_s = ST_IDLE;
            default:  next_state_s = ST_IDLE;
        endcase
    end

    // Stall holds the pipeline while an access is detected or outstanding
    always_comb begin
        if (state_r == ST_REQ) begin
            stall_s = 1'b1;
        end else if (state_r == ST_IDLE) begin
            stall_s = access_s;
        end else begin
            stall_s = 1'b0;
        end
    end

    // State, timeout counter and registered memory-side outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= CNT_ZERO;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 32'h0000_0000;
            mem_wdata_r <= 32'h0000_0000;
            err_r       <= 1'b0;
        end else begin
            state_r   <= next_state_s;
            mem_req_r <= (next_state_s == ST_REQ);
            err_r     <= (next_state_s == ST_FAULT);
            if ((state_r == ST_IDLE) && (next_state_s == ST_REQ)) begin
                mem_addr_r  <= {bus.address[31:2], 2'b00};
                mem_wdata_r <= bus.data_m;
                mem_we_r    <= bus.MemWrite_m;
                cnt_r       <= CNT_ZERO;
            end else if ((state_r == ST_REQ) && (next_state_s == ST_REQ)) begin
                cnt_r <= cnt_r + CNT_ONE;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Load result: captured on read completion, cleared on any fault
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_r <= 32'h0000_0000;
        end else if ((state_r == ST_REQ) && bus.mem_ack && !mem_we_r) begin
            rdata_r <= bus.mem_rdata;
        end else if (next_state_s == ST_FAULT) begin
            rdata_r <= 32'h0000_0000;
        end else begin
            rdata_r <= rdata_r;
        end
    end

    assign bus.mem_req   = mem_req_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.rdata_o   = rdata_r;
    assign bus.err_o     = err_r;
    assign bus.stall     = stall_s;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: the driver queues the expected
// retirement record of each access; a negedge monitor accumulates stall,
// request and error cycles and compares them when the instruction retires.
module tb_mem_access_ctrl;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    mem_access_ctrl_if bus();

    mem_access_ctrl #(.TIMEOUT(4), .CNT_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int          stalls;
        int          errs;
        logic [31:0] rdata;
        int          reqs;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } exp_t;

    exp_t exp_q[$];

    int n_cmp = 0;
    int n_err = 0;

    // memory model controls
    int          ack_delay;
    logic        force_ack;
    logic [31:0] mem_rdata_val;
    int          req_age;

    // monitor state
    logic        mon_en;
    int          stall_cnt;
    int          req_cnt;
    int          err_cnt;
    logic        cap_we;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input int stalls, input int errs, input logic [31:0] rdata,
                                input int reqs, input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata);
        exp_t e;
        e.stalls = stalls; e.errs = errs; e.rdata = rdata; e.reqs = reqs;
        e.we = we; e.addr = addr; e.wdata = wdata;
        return e;
    endfunction

    // Memory model: ack arrives k cycles after mem_req rises (k<0: never)
    initial begin
        req_age       = 0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0000_0000;
        forever begin
            @(posedge clk);
            #2;
            if (bus.mem_req) req_age++;
            else req_age = 0;
            bus.mem_ack   = force_ack || (bus.mem_req && (ack_delay >= 0) && (req_age == ack_delay + 1));
            bus.mem_rdata = mem_rdata_val;
        end
    end

    // Monitor: accumulate per-instruction activity and check at retirement
    initial begin
        exp_t e;
        stall_cnt = 0; req_cnt = 0; err_cnt = 0;
        cap_we = 1'b0; cap_addr = 32'h0; cap_wdata = 32'h0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                stall_cnt = 0; req_cnt = 0; err_cnt = 0;
            end else begin
                if (bus.mem_req) begin
                    req_cnt++;
                    cap_we    = bus.mem_we;
                    cap_addr  = bus.mem_addr;
                    cap_wdata = bus.mem_wdata;
                end
                if (bus.stall) stall_cnt++;
                if (bus.err_o) err_cnt++;
                if ((bus.MemRead_m || bus.MemWrite_m) && !bus.stall) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL retire_unexpected: got retirement expected none");
                    end else begin
                        e = exp_q.pop_front();
                        chk("stall_cycles", stall_cnt, e.stalls);
                        chk("err_cycles",   err_cnt,   e.errs);
                        chk("rdata_o",      bus.rdata_o, e.rdata);
                        chk("req_cycles",   req_cnt,   e.reqs);
                        if (e.reqs > 0) begin
                            chk("mem_we",    cap_we,    e.we);
                            chk("mem_addr",  cap_addr,  e.addr);
                            chk("mem_wdata", cap_wdata, e.wdata);
                        end
                    end
                    stall_cnt = 0; req_cnt = 0; err_cnt = 0;
                end
            end
        end
    end

    // Driver: present one instruction and hold it until it retires
    task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                             input logic [31:0] d, input int k, input logic [31:0] rv,
                             input exp_t e);
        int n;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        ack_delay      = k;
        mem_rdata_val  = rv;
        bus.MemRead_m  = rd;
        bus.MemWrite_m = wr;
        bus.address    = a;
        bus.data_m     = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.stall && (n < 50));
        if (bus.stall) begin
            n_cmp++;
            n_err++;
            $display("FAIL retire_timeout: got stall after %0d cycles expected retirement", n);
        end
    endtask

    task automatic clear_inputs();
        bus.MemRead_m  = 1'b0;
        bus.MemWrite_m = 1'b0;
        bus.address    = 32'h0000_0000;
        bus.data_m     = 32'h0000_0000;
    endtask

    initial begin
        rst_n         = 1'b0;
        mon_en        = 1'b0;
        ack_delay     = -1;
        force_ack     = 1'b0;
        mem_rdata_val = 32'h0000_0000;
        clear_inputs();

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_req",   bus.mem_req,   32'd0);
        chk("rst_mem_we",    bus.mem_we,    32'd0);
        chk("rst_mem_addr",  bus.mem_addr,  32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst_rdata_o",   bus.rdata_o,   32'd0);
        chk("rst_err_o",     bus.err_o,     32'd0);
        chk("rst_stall",     bus.stall,     32'd0);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // load, ack 3 cycles after request (last REQ cycle before timeout)
        do_access(1'b1, 1'b0, 32'h0000_0040, 32'hAAAA_5555, 3, 32'hDEAD_BEEF,
                  mk(5, 0, 32'hDEAD_BEEF, 4, 1'b0, 32'h0000_0040, 32'hAAAA_5555));
        // store, ack in first REQ cycle; rdata_o must not change
        do_access(1'b0, 1'b1, 32'h0000_0100, 32'h1234_5678, 0, 32'h5555_AAAA,
                  mk(2, 0, 32'hDEAD_BEEF, 1, 1'b1, 32'h0000_0100, 32'h1234_5678));
        // misaligned load
        do_access(1'b1, 1'b0, 32'h0000_0042, 32'hAAAA_5555, 0, 32'h5555_AAAA,
                  mk(1, 1, 32'h0000_0000, 0, 1'b0, 32'h0, 32'h0));
        // load, ack one cycle late
        do_access(1'b1, 1'b0, 32'h0000_0080, 32'hAAAA_5555, 1, 32'hCAFE_F00D,
                  mk(3, 0, 32'hCAFE_F00D, 2, 1'b0, 32'h0000_0080, 32'hAAAA_5555));
        // read and write together at aligned address
        do_access(1'b1, 1'b1, 32'h0000_0000, 32'h0000_0000, 0, 32'h5555_AAAA,
                  mk(1, 1, 32'h0000_0000, 0, 1'b0, 32'h0, 32'h0));
        // load that never gets an ack: 4 REQ cycles then fault
        do_access(1'b1, 1'b0, 32'h0000_0200, 32'hAAAA_5555, -1, 32'h5555_AAAA,
                  mk(5, 1, 32'h0000_0000, 4, 1'b0, 32'h0000_0200, 32'hAAAA_5555));
        // back-to-back store right after the timeout fault
        do_access(1'b0, 1'b1, 32'h0000_0300, 32'h0BAD_CAFE, 0, 32'h5555_AAAA,
                  mk(2, 0, 32'h0000_0000, 1, 1'b1, 32'h0000_0300, 32'h0BAD_CAFE));
        // minimal load
        do_access(1'b1, 1'b0, 32'h0000_0204, 32'h0000_0000, 0, 32'h1357_9BDF,
                  mk(2, 0, 32'h1357_9BDF, 1, 1'b0, 32'h0000_0204, 32'h0000_0000));
        // misaligned store
        do_access(1'b0, 1'b1, 32'h0000_0101, 32'hFFFF_0000, 0, 32'h5555_AAAA,
                  mk(1, 1, 32'h0000_0000, 0, 1'b0, 32'h0, 32'h0));

        @(posedge clk);
        #1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b0;

        // reset in the middle of an outstanding load
        ack_delay     = -1;
        bus.MemRead_m = 1'b1;
        bus.address   = 32'h0000_0400;
        bus.data_m    = 32'h7777_8888;
        repeat (2) @(posedge clk);
        #1;
        chk("midreq_req_high", bus.mem_req, 32'd1);
        rst_n = 1'b0;
        clear_inputs();
        @(posedge clk);
        @(negedge clk);
        chk("midrst_mem_req",   bus.mem_req,   32'd0);
        chk("midrst_mem_addr",  bus.mem_addr,  32'd0);
        chk("midrst_mem_wdata", bus.mem_wdata, 32'd0);
        chk("midrst_rdata_o",   bus.rdata_o,   32'd0);
        chk("midrst_err_o",     bus.err_o,     32'd0);
        chk("midrst_stall",     bus.stall,     32'd0);
        @(posedge clk);
        #1;
        rst_n         = 1'b1;
        force_ack     = 1'b1;
        mem_rdata_val = 32'hFFFF_FFFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("lateack_mem_req", bus.mem_req, 32'd0);
        chk("lateack_rdata_o", bus.rdata_o, 32'd0);
        chk("lateack_err_o",   bus.err_o,   32'd0);
        chk("lateack_stall",   bus.stall,   32'd0);
        force_ack = 1'b0;

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Memory-stage access controller sitting between the EX/MEM pipeline register outputs and a variable-latency data memory port. It turns each load/store presented by the EX/MEM register into a single request/acknowledge transaction, stalls the whole pipeline until the transaction completes, and returns load data for the MEM/WB register. Misaligned accesses, illegal read+write combinations and memory timeouts are reported as a one-cycle fault pulse.

## Interface
- TIMEOUT, 16: cycles in REQ without `mem_ack` before the access is abandoned (≥1).
- CNT_W, 5: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

- clk  in  1  pipeline clock; all state changes on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- MemRead_m  in  1  load in MEM stage (from EX/MEM register).
- MemWrite_m  in  1  store in MEM stage.
- address  in  32  byte address from EX/MEM register.
- data_m  in  32  store data from EX/MEM register.
- mem_req  out  1  request to data memory (registered).
- mem_we  out  1  1 = write, 0 = read; valid while mem_req=1.
- mem_addr  out  32  latched word-aligned address.
- mem_wdata  out  32  latched store data.
- mem_ack  in  1  memory completion; meaningful only while mem_req=1.
- mem_rdata  in  32  read data, valid with mem_ack on reads.
- stall  out  1  combinational; freeze PC, IF/ID, ID/EX, EX/MEM.
- rdata_o  out  32  registered load result for MEM/WB.
- err_o  out  1  one-cycle fault pulse.

## Operation
- States: IDLE, REQ, DONE, FAULT.
- access = MemRead_m | MemWrite_m. illegal = (MemRead_m & MemWrite_m) | (address[1:0] != 0).
- IDLE: access & ~illegal → REQ; latch mem_addr=address, mem_wdata=data_m, mem_we=MemWrite_m; set mem_req=1; clear counter. access & illegal → FAULT, no memory request. Otherwise stay in IDLE.
- REQ: mem_ack=1 → DONE; mem_req=0; on a read, rdata_o=mem_rdata. Otherwise the counter increments; when the counter equals TIMEOUT-1 with no ack → FAULT, mem_req=0.
- DONE: unconditional → IDLE. The pipeline advances at the end of this cycle.
- FAULT: err_o=1; rdata_o=0; unconditional → IDLE.
- stall = (IDLE & access) | REQ. stall is 0 in DONE and FAULT.
- mem_we, mem_addr, mem_wdata hold their values outside REQ. rdata_o holds its value until the next read completion or fault. Writes never change rdata_o.
- mem_ack while mem_req=0 is ignored (no state or data change).

## Timing
- Reset (rst_n=0 at an edge): state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata_o=0, err_o=0, counter=0.
- Reset mid-transaction: the access is abandoned and mem_req=0 after that edge. A late ack is ignored.
- Minimum access with ack in the first REQ cycle:
  - cycle 0: IDLE, stall=1.
  - cycle 1: REQ, mem_req=1, ack sampled.
  - cycle 2: DONE, stall=0, rdata_o valid.
  - The instruction occupies MEM for 3 cycles (2 stall cycles).
- An ack arriving k cycles after mem_req rises gives k+2 stall cycles.
- Timeout: exactly TIMEOUT REQ cycles, then one FAULT cycle.
- Back-to-back accesses: the next instruction appears in EX/MEM the cycle after DONE/FAULT, with the controller already in IDLE. There is no dead cycle beyond the IDLE detect cycle.
- Illegal access: 1 stall cycle (IDLE), then FAULT with err_o=1. mem_req never rises.

## Test plan
- Reset with rst_n=0 while in REQ → next edge mem_req=0, state IDLE, all outputs 0. A later mem_ack=1 produces no change.
- Load at address=0x0000_0040, mem_rdata=0xDEAD_BEEF, ack 3 cycles after mem_req → mem_we=0 and mem_addr=0x40 throughout; stall=1 for 5 cycles; rdata_o=0xDEAD_BEEF in DONE; err_o stays 0.
- Store at address=0x0000_0100, data_m=0x1234_5678, ack in the first REQ cycle → mem_we=1, mem_wdata=0x1234_5678; stall high for exactly 2 cycles; rdata_o unchanged.
- Load at address=0x0000_0042 → stall=1 for 1 cycle; err_o=1 for 1 cycle; mem_req never asserted; rdata_o=0.
- MemRead_m=MemWrite_m=1 at aligned address 0x0 → same response as the misaligned load: FAULT, no request.
- TIMEOUT=4, no ack → mem_req high for exactly 4 cycles, then err_o pulses once. A back-to-back store then issues normally, with mem_req rising 2 cycles after the fault.
